// File: rtl/clk_pkg.sv
// Shared definitions for the clock front-panel blocks.
//   - display mode and digit-pair position encodings with their widths
//   - button index map used by the controller's event vector
//   - small step helpers for the mode and position rings
package clk_pkg;

    localparam int MODE_W  = 2;
    localparam int POS_W   = 2;
    localparam int NUM_BTN = 4;

    // Bit positions in the controller's button/event vector.
    localparam int BTN_MODE = 0;
    localparam int BTN_POS  = 1;
    localparam int BTN_CLR  = 2;
    localparam int BTN_UP   = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_e;

    typedef enum logic [POS_W-1:0] {
        POS_SEC  = 2'b00,
        POS_MIN  = 2'b01,
        POS_HOUR = 2'b10
    } pos_e;

    function automatic logic is_setting(input mode_e m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_CLOCK:     return MODE_SET_TIME;
            MODE_SET_TIME:  return MODE_SET_ALARM;
            MODE_SET_ALARM: return MODE_STOPWATCH;
            default:        return MODE_CLOCK;
        endcase
    endfunction

    // 2'b11 is unreachable; fold it back to the start of the ring.
    function automatic pos_e next_pos(input pos_e p);
        case (p)
            POS_SEC: return POS_MIN;
            POS_MIN: return POS_HOUR;
            default: return POS_SEC;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge pulse.
//   clk, rst : system clock, async active-high reset
//   i_lvl    : debounced button level, asynchronous to clk
//   o_rise   : one-cycle pulse, high between edges N+1 and N+2 when i_lvl
//              was first seen high at edge N
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = i_lvl;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/mode_pos_ctrl.sv
// Front-panel controller for the six-digit clock display.
// Turns four buttons into display mode / digit-pair position, increment and
// clear strobes, a stopwatch run flag, an idle auto-return and a blink phase.
//   clk, rst        : system clock, async active-high reset
//   i_sw_mode/pos/up/clr : debounced button levels (asynchronous)
//   i_sec_tick      : one-cycle pulse per second
//   o_mode          : 00 CLOCK, 01 SET_TIME, 10 SET_ALARM, 11 STOPWATCH
//   o_position      : 00 seconds, 01 minutes, 10 hours pair
//   o_inc_sec/min/hour : one-cycle increment strobes for the selected field
//   o_sw_run, o_sw_clr : stopwatch run flag and one-cycle clear strobe
//   o_blink         : digit-on phase for the selected pair
module mode_pos_ctrl
    import clk_pkg::*;
#(
    parameter int IDLE_SEC   = 30,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sw_mode,
    input  logic              i_sw_pos,
    input  logic              i_sw_up,
    input  logic              i_sw_clr,
    input  logic              i_sec_tick,
    output logic [MODE_W-1:0] o_mode,
    output logic [POS_W-1:0]  o_position,
    output logic              o_inc_sec,
    output logic              o_inc_min,
    output logic              o_inc_hour,
    output logic              o_sw_run,
    output logic              o_sw_clr,
    output logic              o_blink
);

    localparam int         BW         = $clog2(BLINK_HALF > 1 ? BLINK_HALF : 2);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(IDLE_SEC - 1);

    logic [NUM_BTN-1:0] sw_raw, ev;

    assign sw_raw = {i_sw_up, i_sw_clr, i_sw_pos, i_sw_mode};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_edge u_btn (
            .clk    (clk),
            .rst    (rst),
            .i_lvl  (sw_raw[g]),
            .o_rise (ev[g])
        );
    end

    mode_e         mode_q, mode_d;
    pos_e          pos_q, pos_d;
    logic          run_q, run_d;
    logic          clr_q, clr_d;
    logic [2:0]    inc_q, inc_d;
    logic [7:0]    idle_q, idle_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic          setting, accepted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_CLOCK;
            pos_q   <= POS_SEC;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            inc_q   <= '0;
            idle_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            inc_q   <= inc_d;
            idle_q  <= idle_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    // Next state. The if/else chain is the event priority: only the winning
    // event is acted on, even when the winner itself is ignored in this mode.
    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        run_d    = run_q;
        idle_d   = idle_q;
        inc_d    = '0;
        clr_d    = 1'b0;
        accepted = 1'b0;
        setting  = is_setting(mode_q);

        if (ev[BTN_MODE]) begin
            mode_d   = next_mode(mode_q);
            pos_d    = POS_SEC;
            accepted = 1'b1;
        end else if (ev[BTN_POS]) begin
            if (setting) begin
                pos_d    = next_pos(pos_q);
                accepted = 1'b1;
            end
        end else if (ev[BTN_CLR]) begin
            if (mode_q == MODE_STOPWATCH) begin
                clr_d = 1'b1;
                run_d = 1'b0;
            end
        end else if (ev[BTN_UP]) begin
            if (setting) begin
                accepted = 1'b1;
                case (pos_q)
                    POS_SEC: inc_d[0] = 1'b1;
                    POS_MIN: inc_d[1] = 1'b1;
                    default: inc_d[2] = 1'b1;
                endcase
            end else if (mode_q == MODE_STOPWATCH) begin
                run_d = ~run_q;
            end
        end

        // An accepted event beats a coincident tick, so no timeout then.
        if (!setting || accepted) begin
            idle_d = '0;
        end else if (i_sec_tick) begin
            if (idle_q == IDLE_LAST) begin
                mode_d = MODE_CLOCK;
                pos_d  = POS_SEC;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end

        // Any change of mode or position restarts the blink phase digit-on.
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (!is_setting(mode_d) || (mode_d != mode_q) || (pos_d != pos_q)) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    always_comb begin
        o_mode     = mode_q;
        o_position = pos_q;
        o_inc_sec  = inc_q[0];
        o_inc_min  = inc_q[1];
        o_inc_hour = inc_q[2];
        o_sw_run   = run_q;
        o_sw_clr   = clr_q;
        o_blink    = blink_q;
    end

endmodule

// File: tb/tb_mode_pos_ctrl.sv
module tb_mode_pos_ctrl;

    localparam int IDLE = 3;
    localparam int BH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;   // 0 mode, 1 pos, 2 clr, 3 up
    logic       tick = 1'b0;
    logic [1:0] o_mode, o_position;
    logic       o_inc_sec, o_inc_min, o_inc_hour, o_sw_run, o_sw_clr, o_blink;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_pos_ctrl #(.IDLE_SEC(IDLE), .BLINK_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_sw_mode  (btn[0]),
        .i_sw_pos   (btn[1]),
        .i_sw_up    (btn[3]),
        .i_sw_clr   (btn[2]),
        .i_sec_tick (tick),
        .o_mode     (o_mode),
        .o_position (o_position),
        .o_inc_sec  (o_inc_sec),
        .o_inc_min  (o_inc_min),
        .o_inc_hour (o_inc_hour),
        .o_sw_run   (o_sw_run),
        .o_sw_clr   (o_sw_clr),
        .o_blink    (o_blink)
    );

    // Reference model: a button level seen at edge k-2 but not at k-3 is an
    // event acted on at edge k; then the panel rules are applied directly.
    logic [3:0] h1, h2, h3;
    int   m_mode, m_pos, m_idle, cyc, m_bstart;
    bit   m_run, m_clr;
    bit [2:0] m_inc;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] ev;
        int md, ps, id;
        bit rn, cl, acc, setm;
        bit [2:0] inc;
        if (rst) begin
            h1 <= '0; h2 <= '0; h3 <= '0;
            m_mode <= 0; m_pos <= 0; m_idle <= 0; m_run <= 0; m_clr <= 0; m_inc <= '0;
            cyc <= 0; m_bstart <= 0;
        end else begin
            ev = h2 & ~h3;
            md = m_mode; ps = m_pos; id = m_idle; rn = m_run;
            cl = 0; inc = '0; acc = 0;
            setm = (m_mode == 1) || (m_mode == 2);
            if (ev[0]) begin
                md = (md + 1) % 4; ps = 0; acc = 1;
            end else if (ev[1]) begin
                if (setm) begin ps = (ps + 1) % 3; acc = 1; end
            end else if (ev[2]) begin
                if (m_mode == 3) begin cl = 1; rn = 0; end
            end else if (ev[3]) begin
                if (setm) begin inc[ps] = 1'b1; acc = 1; end
                else if (m_mode == 3) rn = !rn;
            end
            if (!setm || acc) id = 0;
            else if (tick) begin
                if (id == IDLE - 1) begin md = 0; ps = 0; id = 0; end
                else id = id + 1;
            end
            if (md != m_mode || ps != m_pos) m_bstart <= cyc + 1;
            cyc <= cyc + 1;
            m_mode <= md; m_pos <= ps; m_idle <= id; m_run <= rn; m_clr <= cl; m_inc <= inc;
            h3 <= h2; h2 <= h1; h1 <= btn;
        end
    end

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (3) @(negedge clk);
        btn[b] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sec_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_mode, o_position, o_sw_run, o_blink} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL reset_vals: got mode=%b pos=%b run=%b blink=%b, want 00 00 0 1",
                     o_mode, o_position, o_sw_run, o_blink);
        end
        checks++;
        if ({o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, want 0000",
                     {o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_mode, o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: got mode=%b strobes=%b, want 00 0000",
                     o_mode, {o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr});
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] prev, want;
        for (int i = 0; i < 4; i++) begin
            prev = o_mode;
            want = 2'(i + 1);
            btn[0] = 1'b1;
            repeat (2) @(negedge clk);
            checks++;
            if (o_mode !== prev) begin
                errors++;
                $display("FAIL mode_early[%0d]: got %b, want %b", i, o_mode, prev);
            end
            @(negedge clk);
            checks++;
            if (o_mode !== want || o_position !== 2'b00) begin
                errors++;
                $display("FAIL mode_step[%0d]: got mode=%b pos=%b, want %b 00", i, o_mode, o_position, want);
            end
            btn[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_pos_up();
        logic [1:0] want;
        int n_sec, n_min, n_hour, at;
        press(0);
        for (int i = 1; i <= 3; i++) begin
            press(1);
            want = 2'(i % 3);
            checks++;
            if (o_position !== want) begin
                errors++;
                $display("FAIL pos_step[%0d]: got %b, want %b", i, o_position, want);
            end
        end
        press(1);
        n_sec = 0; n_min = 0; n_hour = 0; at = -1;
        btn[3] = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (o_inc_min === 1'b1) begin n_min++; at = c; end
            if (o_inc_sec === 1'b1) n_sec++;
            if (o_inc_hour === 1'b1) n_hour++;
        end
        btn[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_min != 1 || at != 3) begin
            errors++;
            $display("FAIL up_hold_min: got %0d strobes at cycle %0d, want 1 at cycle 3", n_min, at);
        end
        checks++;
        if (n_sec != 0 || n_hour != 0) begin
            errors++;
            $display("FAIL up_other_fields: got sec=%0d hour=%0d, want 0 0", n_sec, n_hour);
        end
    endtask

    task automatic test_stopwatch();
        press(0); press(0);
        press(3);
        checks++;
        if (o_mode !== 2'b11 || o_sw_run !== 1'b1) begin
            errors++;
            $display("FAIL sw_start: got mode=%b run=%b, want 11 1", o_mode, o_sw_run);
        end
        press(0);
        checks++;
        if (o_mode !== 2'b00 || o_sw_run !== 1'b1) begin
            errors++;
            $display("FAIL sw_background: got mode=%b run=%b, want 00 1", o_mode, o_sw_run);
        end
        press(0); press(0); press(0);
        btn[2] = 1'b1; btn[3] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_sw_clr !== 1'b0 || o_sw_run !== 1'b1) begin
            errors++;
            $display("FAIL sw_clr_early: got clr=%b run=%b, want 0 1", o_sw_clr, o_sw_run);
        end
        @(negedge clk);
        checks++;
        if (o_sw_clr !== 1'b1 || o_sw_run !== 1'b0) begin
            errors++;
            $display("FAIL sw_clr_pulse: got clr=%b run=%b, want 1 0", o_sw_clr, o_sw_run);
        end
        @(negedge clk);
        checks++;
        if (o_sw_clr !== 1'b0 || o_sw_run !== 1'b0) begin
            errors++;
            $display("FAIL sw_clr_after: got clr=%b run=%b, want 0 0", o_sw_clr, o_sw_run);
        end
        btn[2] = 1'b0; btn[3] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idle();
        logic [1:0] want;
        press(0); press(0); press(0);
        for (int t = 1; t <= 3; t++) begin
            sec_tick();
            want = (t == 3) ? 2'b00 : 2'b10;
            checks++;
            if (o_mode !== want) begin
                errors++;
                $display("FAIL idle_tick[%0d]: got mode=%b, want %b", t, o_mode, want);
            end
        end
        press(0); press(0);
        sec_tick();
        btn[3] = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        btn[3] = 1'b0;
        repeat (2) @(negedge clk);
        for (int t = 1; t <= 3; t++) begin
            sec_tick();
            want = (t == 3) ? 2'b00 : 2'b10;
            checks++;
            if (o_mode !== want) begin
                errors++;
                $display("FAIL idle_rearm[%0d]: got mode=%b, want %b", t, o_mode, want);
            end
        end
    endtask

    task automatic test_blink();
        logic want;
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k == 2) btn[0] = 1'b0;
            want = ((k / BH) % 2) == 0;
            checks++;
            if (o_blink !== want) begin
                errors++;
                $display("FAIL blink_phase[%0d]: got %b, want %b", k, o_blink, want);
            end
            if (k == 9) btn[1] = 1'b1;
            @(negedge clk);
        end
        for (int j = 0; j < 12; j++) begin
            if (j == 1) btn[1] = 1'b0;
            want = ((j / BH) % 2) == 0;
            checks++;
            if (o_blink !== want || o_position !== 2'b01) begin
                errors++;
                $display("FAIL blink_restart[%0d]: got blink=%b pos=%b, want %b 01", j, o_blink, o_position, want);
            end
            @(negedge clk);
        end
        press(0); press(0); press(0);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (o_blink !== 1'b1 || o_mode !== 2'b00) begin
                errors++;
                $display("FAIL blink_clock[%0d]: got blink=%b mode=%b, want 1 00", k, o_blink, o_mode);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic exp_blink;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exp_blink = (m_mode == 1 || m_mode == 2) ? (((cyc - m_bstart) / BH) % 2 == 0) : 1'b1;
            checks++;
            if (o_mode !== 2'(m_mode) || o_position !== 2'(m_pos) || o_sw_run !== m_run ||
                o_sw_clr !== m_clr || {o_inc_hour, o_inc_min, o_inc_sec} !== m_inc ||
                o_blink !== exp_blink) begin
                errors++;
                $display("FAIL rand[%0d]: got m=%b p=%b r=%b c=%b inc=%b b=%b, want m=%0d p=%0d r=%b c=%b inc=%b b=%b",
                         c, o_mode, o_position, o_sw_run, o_sw_clr,
                         {o_inc_hour, o_inc_min, o_inc_sec}, o_blink,
                         m_mode, m_pos, m_run, m_clr, m_inc, exp_blink);
            end
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            tick = ($urandom_range(0, 15) == 0);
        end
        btn = '0;
        tick = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4 && o_mode !== 2'b11; i++) press(0);
        if (o_sw_run !== 1'b1) press(3);
        checks++;
        if (o_mode !== 2'b11 || o_sw_run !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: got mode=%b run=%b, want 11 1", o_mode, o_sw_run);
        end
        btn[3] = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_mode, o_position, o_sw_run, o_blink, o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr}
                !== 10'b00_00_0_1_0000) begin
            errors++;
            $display("FAIL arst_immediate: got mode=%b pos=%b run=%b blink=%b, want 00 00 0 1",
                     o_mode, o_position, o_sw_run, o_blink);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr, o_sw_run} !== 5'b0 || o_mode !== 2'b00) begin
                errors++;
                $display("FAIL arst_release[%0d]: got strobes=%b run=%b mode=%b, want 0000 0 00",
                         k, {o_inc_sec, o_inc_min, o_inc_hour, o_sw_clr}, o_sw_run, o_mode);
            end
        end
        btn[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_pos_up();
        test_stopwatch();
        test_idle();
        test_blink();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
